// File: rtl/aes_pkg.sv
// Shared AES-128 types, round constants and byte-level transform functions
// used by the round sequencer and its key-schedule step.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } seq_state_e;

  localparam int NR = 10;

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 through a short addition chain, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(x240, x14);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[i*8 +: 8] = sbox(s[i*8 +: 8]);
    return o;
  endfunction

  // Byte n sits at [127-8n -: 8]; row = n % 4, column = n / 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes128_round_sequencer_if.sv
// Request/result handshake bundle between a requester/consumer (master) and the sequencer (slave).
interface aes128_round_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plain_text;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] cipher_text;

  modport master (
    output in_valid, plain_text, key, out_ready,
    input  in_ready, out_valid, cipher_text
  );

  modport slave (
    input  in_valid, plain_text, key, out_ready,
    output in_ready, out_valid, cipher_text
  );
endinterface

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: RotWord/SubWord on the last word, then cascaded word XORs.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  output logic [127:0] key_out
);
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_word, sub_word, temp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_in;
  assign rot_word = {w3[23:0], w3[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sub_word
      assign sub_word[gi*8 +: 8] = sbox(rot_word[gi*8 +: 8]);
    end
  endgenerate

  assign temp = sub_word ^ {rcon, 24'h000000};
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign key_out = {n0, n1, n2, n3};
endmodule

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryption controller: one round per cycle, round keys derived on the fly.
// Optional macro AES_CLEAR_ON_DONE_EN wipes state and key registers on the output handshake.
module aes128_round_sequencer
  import aes_pkg::*;
(
  input logic                      clock,
  input logic                      reset,
  aes128_round_sequencer_if.slave  bus
);
  seq_state_e   fsm_reg, fsm_next;
  logic [3:0]   round_reg;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [127:0] round_key;
  logic [127:0] shifted;
  logic [127:0] round_data;
  logic         last_round;

  assign last_round = (round_reg >= 4'(NR));

  aes_key_step u_key_step (
    .key_in  (key_reg),
    .rcon    (rcon_of(round_reg)),
    .key_out (round_key)
  );

  assign shifted    = shift_rows(sub_bytes(state_reg));
  assign round_data = (last_round ? shifted : mix_columns(shifted)) ^ round_key;

  always_ff @(posedge clock) begin
    if (reset) fsm_reg <= IDLE;
    else       fsm_reg <= fsm_next;
  end

  always_comb begin
    fsm_next = IDLE;
    case (fsm_reg)
      IDLE:    fsm_next = bus.in_valid ? ROUND : IDLE;
      ROUND:   fsm_next = last_round ? DONE : ROUND;
      DONE:    fsm_next = bus.out_ready ? IDLE : DONE;
      default: fsm_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (fsm_reg)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.cipher_text = state_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      round_reg <= '0;
      state_reg <= '0;
      key_reg   <= '0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg <= bus.plain_text ^ bus.key;
            key_reg   <= bus.key;
            round_reg <= 4'd1;
          end
        end
        ROUND: begin
          key_reg   <= round_key;
          state_reg <= round_data;
          round_reg <= last_round ? 4'd0 : round_reg + 4'd1;
        end
        DONE: begin
`ifdef AES_CLEAR_ON_DONE_EN
          if (bus.out_ready) begin
            state_reg <= '0;
            key_reg   <= '0;
          end
`endif
        end
        default: round_reg <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Self-checking bench for aes128_round_sequencer: FIPS-197 vectors, handshake corner cases
// and randomized requests against a table-driven AES reference model.
module tb_aes128_round_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  aes128_round_sequencer_if bus ();

  aes128_round_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [7:0] sb [256];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // S-box table by exhaustive search for each field inverse.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) t[j] = sb[s[j]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row+4*c] = t[row+4*((c+row)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting clock edge.
  task automatic send(input logic [127:0] pt, input logic [127:0] k);
    int n;
    bus.plain_text = pt;
    bus.key        = k;
    bus.in_valid   = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("accept_ready", 128'(bus.in_ready), 128'(1));
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  // pre: cycles already elapsed since the accept edge.
  task automatic collect(input logic [127:0] exp, input int stall, input int pre);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check("latency", 128'(pre + lat), 128'(10));
    check("cipher", bus.cipher_text, exp);
    $display("txn pt=%h key=%h ct=%h lat=%0d stall=%0d",
             bus.plain_text, bus.key, bus.cipher_text, pre + lat, stall);
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      check("hold_valid", 128'(bus.out_valid), 128'(1));
      check("hold_cipher", bus.cipher_text, exp);
      check("hold_busy", 128'(bus.in_ready), 128'(0));
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    check("post_valid", 128'(bus.out_valid), 128'(0));
    check("post_ready", 128'(bus.in_ready), 128'(1));
    for (int i = 0; i < 2; i++) begin
`ifdef AES_CLEAR_ON_DONE_EN
      check("post_cipher", bus.cipher_text, 128'h0);
`else
      check("post_cipher", bus.cipher_text, exp);
`endif
      @(negedge clock);
    end
  endtask

  initial begin
    int acc [$];
    int nres, n;
    logic [127:0] pt, k;

    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.plain_text = '0;
    bus.key        = '0;
    build_sbox();
    check("model_fips_b", ref_encrypt(PT1, K1), CT1);
    check("model_fips_c1", ref_encrypt(PT2, K2), CT2);

    @(negedge clock);
    @(negedge clock);
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_cipher", bus.cipher_text, 128'h0);
    reset = 1'b0;
    @(negedge clock);

    // FIPS-197 App.B, immediate consumption
    send(PT1, K1);
    collect(CT1, 0, 0);

    // App.C.1 back-to-back with request and result always asserted
    bus.plain_text = PT2;
    bus.key        = K2;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b1;
    nres = 0;
    n    = 0;
    while (nres < 2 && n < 60) begin
      if (acc.size() >= 2) bus.in_valid = 1'b0;
      if (bus.in_ready && bus.in_valid) acc.push_back(cyc);
      if (bus.out_valid) begin
        check("b2b_cipher", bus.cipher_text, CT2);
        nres++;
      end
      @(negedge clock);
      n++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_results", 128'(nres), 128'(2));
    check("b2b_spacing", 128'(acc.size() == 2 ? acc[1] - acc[0] : -1), 128'(12));
    $display("txn back-to-back pt=%h key=%h results=%0d", PT2, K2, nres);
    @(negedge clock);

    // Backpressure for 20 cycles
    send(PT1, K1);
    collect(CT1, 20, 0);

    // Busy stimulus must not be accepted
    send(PT1, K1);
    for (int i = 0; i < 9; i++) begin
      bus.in_valid   = 1'($urandom_range(0, 1));
      bus.plain_text = rand128();
      bus.key        = rand128();
      check("busy_no_ready", 128'(bus.in_ready), 128'(0));
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    collect(CT1, 0, 9);

    // Reset while round 5 is pending
    send(PT1, K1);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    check("midrst_in_ready", 128'(bus.in_ready), 128'(1));
    check("midrst_cipher", bus.cipher_text, 128'h0);
    $display("txn reset at round 5");
    send(PT2, K2);
    collect(CT2, 0, 0);

    // Randomized requests against the model
    for (int v = 0; v < 10; v++) begin
      pt = rand128();
      k  = rand128();
      repeat ($urandom_range(0, 2)) @(negedge clock);
      send(pt, k);
      collect(ref_encrypt(pt, k), int'($urandom_range(0, 3)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
